// File: rtl/cpu_ctrl_if.sv
// Bus bundle between the accumulator-machine controller and its instruction/data memories.
// master is the controller side, slave is the memory/environment side.
interface cpu_ctrl_if;
  logic       iRun;
  logic [7:0] iInst;
  logic       iMemAck;
  logic [3:0] oPC;
  logic [2:0] oAluOp;
  logic       oAccWe;
  logic       oMemReq;
  logic       oMemWr;
  logic [3:0] oMemAddr;
  logic       oHalt;
  logic       oIllegal;
  logic       oFault;

  modport master (
    input  iRun, iInst, iMemAck,
    output oPC, oAluOp, oAccWe, oMemReq, oMemWr, oMemAddr, oHalt, oIllegal, oFault
  );

  modport slave (
    output iRun, iInst, iMemAck,
    input  oPC, oAluOp, oAccWe, oMemReq, oMemWr, oMemAddr, oHalt, oIllegal, oFault
  );
endinterface

// File: rtl/cpu_ctrl.sv
// Multi-cycle controller for a 4-bit-PC accumulator machine: fetch/decode/execute with a
// bounded-wait data-memory phase, sticky illegal-opcode and memory-timeout flags.
module cpu_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input logic        iClk,
  input logic        iRst,
  cpu_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StHalt
  } state_e;

  localparam logic [2:0] OpClr  = 3'b000;
  localparam logic [2:0] OpCom  = 3'b001;
  localparam logic [2:0] OpShr  = 3'b010;
  localparam logic [2:0] OpCsl  = 3'b011;
  localparam logic [2:0] OpAdd  = 3'b100;
  localparam logic [2:0] OpLoad = 3'b101;

  // Last wait count that may still see an ack; beyond it the access faults.
  localparam logic [7:0] LastWait = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [2:0] op_q, op_d;
  logic       store_q, store_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] wait_q, wait_d;
  logic       illegal_q, illegal_d;
  logic       fault_q, fault_d;
  logic       acc_we;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      ir_q      <= '0;
      op_q      <= OpClr;
      store_q   <= 1'b0;
      addr_q    <= '0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      op_q      <= op_d;
      store_q   <= store_d;
      addr_q    <= addr_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    op_d      = op_q;
    store_d   = store_q;
    addr_d    = addr_q;
    wait_d    = wait_q;
    illegal_d = illegal_q;
    fault_d   = fault_q;
    unique case (state_q)
      StIdle: begin
        if (bus.iRun) state_d = StFetch;
      end
      StFetch: begin
        ir_d    = bus.iInst;
        state_d = StDecode;
      end
      StDecode: begin
        wait_d  = '0;
        store_d = 1'b0;
        unique casez (ir_q)
          8'h00: begin op_d = OpClr; state_d = StExec; end
          8'h10: begin op_d = OpCom; state_d = StExec; end
          8'h20: begin op_d = OpShr; state_d = StExec; end
          8'h30: begin op_d = OpCsl; state_d = StExec; end
          8'h41: begin op_d = OpAdd; state_d = StMem; end
          8'h42: begin op_d = OpClr; store_d = 1'b1; state_d = StMem; end
          8'b0110_????: begin
            op_d    = OpLoad;
            addr_d  = ir_q[3:0];
            state_d = StMem;
          end
          8'b1111_????: state_d = StHalt;
          default: begin
            illegal_d = 1'b1;
            state_d   = StHalt;
          end
        endcase
      end
      StExec: begin
        pc_d    = pc_q + 4'd1;
        state_d = StFetch;
      end
      StMem: begin
        if (bus.iMemAck) begin
          pc_d    = pc_q + 4'd1;
          state_d = StFetch;
        end else if (wait_q == LastWait) begin
          fault_d = 1'b1;
          state_d = StHalt;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StHalt: ;
      default: state_d = StIdle;
    endcase
  end

  // Reset gates the ack-qualified write so an abandoned access never touches the accumulator.
  always_comb begin
    acc_we = (state_q == StExec) ||
             ((state_q == StMem) && bus.iMemAck && !store_q && !iRst);
    bus.oAccWe   = acc_we;
    bus.oAluOp   = acc_we ? op_q : OpClr;
    bus.oMemReq  = (state_q == StMem);
    bus.oMemWr   = (state_q == StMem) && store_q;
    bus.oPC      = pc_q;
    bus.oMemAddr = addr_q;
    bus.oHalt    = (state_q == StHalt);
    bus.oIllegal = illegal_q;
    bus.oFault   = fault_q;
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Scoreboard bench for cpu_ctrl: directed programs push expected accumulator writes,
// a monitor pops them on every oAccWe pulse; status outputs checked after each program.
module tb_cpu_ctrl;

  typedef struct {
    logic [2:0] op;
    logic [3:0] pc;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] imem [16];
  logic [7:0] prog [$];
  exp_t       exp_q [$];
  int         checks;
  int         failures;
  int         cyc;
  int         run_cyc;
  int         ack_en;
  int         ack_delay;
  int         last_req_len;
  int         wr_reqs;

  cpu_ctrl_if bus ();

  cpu_ctrl #(.MEM_TIMEOUT(15)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  assign bus.iInst = imem[bus.oPC];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Data-memory responder: acks after ack_delay wait cycles of a held request.
  initial begin
    int mem_cnt;
    mem_cnt     = 0;
    bus.iMemAck = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.oMemReq && ack_en != 0) begin
        if (mem_cnt == ack_delay) begin
          bus.iMemAck = 1'b1;
          mem_cnt     = 0;
        end else begin
          bus.iMemAck = 1'b0;
          mem_cnt++;
        end
      end else begin
        bus.iMemAck = 1'b0;
        mem_cnt     = 0;
      end
    end
  end

  // Monitor: every oAccWe pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    int   req_len;
    logic req_prev;
    req_len      = 0;
    req_prev     = 1'b0;
    last_req_len = 0;
    wr_reqs      = 0;
    forever begin
      @(negedge clk);
      #2;
      if (bus.oAccWe) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL acc_we_unexpected actual=1 required=0 op=%0d pc=%0d (t=%0t)",
                   bus.oAluOp, bus.oPC, $time);
        end else begin
          e = exp_q.pop_front();
          chk("acc_alu_op", int'(bus.oAluOp), int'(e.op));
          chk("acc_pc", int'(bus.oPC), int'(e.pc));
          if (e.cyc >= 0) chk("acc_cycle", cyc, e.cyc);
        end
      end else begin
        chk("alu_op_idle", int'(bus.oAluOp), 0);
      end
      if (bus.oMemReq) begin
        if (!req_prev && bus.oMemWr) wr_reqs++;
        req_len++;
      end else if (req_prev) begin
        last_req_len = req_len;
        req_len      = 0;
      end
      req_prev = bus.oMemReq;
    end
  end

  task automatic push(input logic [2:0] op, input logic [3:0] pc, input int c);
    exp_t e;
    e.op  = op;
    e.pc  = pc;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic load_prog(input logic [7:0] fill);
    for (int i = 0; i < 16; i++) imem[i] = (i < prog.size()) ? prog[i] : fill;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("sb_drained", exp_q.size(), 0);
    exp_q.delete();
    chk("rst_pc", int'(bus.oPC), 0);
    chk("rst_mem_addr", int'(bus.oMemAddr), 0);
    chk("rst_halt", int'(bus.oHalt), 0);
    chk("rst_illegal", int'(bus.oIllegal), 0);
    chk("rst_fault", int'(bus.oFault), 0);
    chk("rst_mem_req", int'(bus.oMemReq), 0);
    chk("rst_mem_wr", int'(bus.oMemWr), 0);
    chk("rst_acc_we", int'(bus.oAccWe), 0);
    wr_reqs = 0;
  endtask

  task automatic run_pulse();
    @(negedge clk);
    bus.iRun = 1'b1;
    run_cyc  = cyc;
    @(negedge clk);
    bus.iRun = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int n;
    n = 0;
    while (!bus.oHalt && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("halt_reached", int'(bus.oHalt), 1);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.iRun  = 1'b0;
    ack_en    = 0;
    ack_delay = 0;
    prog      = '{};
    load_prog(8'hF0);
    repeat (2) @(negedge clk);

    // Register instructions: writes at run+3,6,9,12, then STP at PC 4.
    do_reset();
    prog = '{8'h00, 8'h10, 8'h20, 8'h30, 8'hF0};
    load_prog(8'hF0);
    run_pulse();
    push(3'b000, 4'd0, run_cyc + 3);
    push(3'b001, 4'd1, run_cyc + 6);
    push(3'b010, 4'd2, run_cyc + 9);
    push(3'b011, 4'd3, run_cyc + 12);
    wait_halt(40);
    chk("reg_pc", int'(bus.oPC), 4);
    chk("reg_illegal", int'(bus.oIllegal), 0);

    // LDA 0 with ack after two wait cycles.
    do_reset();
    prog = '{8'h60, 8'hF0};
    load_prog(8'hF0);
    ack_en    = 1;
    ack_delay = 2;
    run_pulse();
    push(3'b101, 4'd0, -1);
    wait_halt(40);
    chk("lda_req_len", last_req_len, 3);
    chk("lda_mem_addr", int'(bus.oMemAddr), 0);
    chk("lda_pc", int'(bus.oPC), 1);

    // LDA loads the address, ADD reuses it.
    do_reset();
    prog = '{8'h6A, 8'h41, 8'hF0};
    load_prog(8'hF0);
    ack_delay = 0;
    run_pulse();
    push(3'b101, 4'd0, -1);
    push(3'b100, 4'd1, -1);
    wait_halt(40);
    chk("add_mem_addr", int'(bus.oMemAddr), 10);
    chk("add_pc", int'(bus.oPC), 2);

    // Full program.
    do_reset();
    prog = '{8'h60, 8'h10, 8'h20, 8'h30, 8'h00, 8'h41, 8'h42, 8'hF0};
    load_prog(8'hF0);
    ack_delay = 1;
    run_pulse();
    push(3'b101, 4'd0, -1);
    push(3'b001, 4'd1, -1);
    push(3'b010, 4'd2, -1);
    push(3'b011, 4'd3, -1);
    push(3'b000, 4'd4, -1);
    push(3'b100, 4'd5, -1);
    wait_halt(80);
    chk("full_pc", int'(bus.oPC), 7);
    chk("full_wr_reqs", wr_reqs, 1);
    chk("full_illegal", int'(bus.oIllegal), 0);
    chk("full_mem_addr", int'(bus.oMemAddr), 0);

    // Illegal 0x55 at PC 2; a later iRun must not restart.
    do_reset();
    prog = '{8'h00, 8'h00, 8'h55};
    load_prog(8'hF0);
    run_pulse();
    push(3'b000, 4'd0, -1);
    push(3'b000, 4'd1, -1);
    wait_halt(40);
    chk("ill_flag", int'(bus.oIllegal), 1);
    chk("ill_pc", int'(bus.oPC), 2);
    run_pulse();
    repeat (6) @(negedge clk);
    chk("ill_run_ignored_halt", int'(bus.oHalt), 1);
    chk("ill_run_ignored_pc", int'(bus.oPC), 2);

    // 0x43 sits next to ADD/STA but is undefined.
    do_reset();
    prog = '{8'h43};
    load_prog(8'hF0);
    run_pulse();
    wait_halt(20);
    chk("ill43_flag", int'(bus.oIllegal), 1);
    chk("ill43_pc", int'(bus.oPC), 0);

    // Memory never acks: fault after 15 request cycles.
    do_reset();
    prog = '{8'h60, 8'hF0};
    load_prog(8'hF0);
    ack_en = 0;
    run_pulse();
    wait_halt(60);
    chk("to_fault", int'(bus.oFault), 1);
    chk("to_req_len", last_req_len, 15);
    chk("to_mem_req_low", int'(bus.oMemReq), 0);
    chk("to_pc", int'(bus.oPC), 0);

    // Ack in the 15th request cycle is still honoured.
    do_reset();
    ack_en    = 1;
    ack_delay = 14;
    run_pulse();
    push(3'b101, 4'd0, -1);
    wait_halt(60);
    chk("late_ack_fault", int'(bus.oFault), 0);
    chk("late_ack_req_len", last_req_len, 15);
    chk("late_ack_pc", int'(bus.oPC), 1);

    // Reset in the second MEM cycle, coinciding with the ack.
    do_reset();
    prog = '{8'h6A, 8'hF0};
    load_prog(8'hF0);
    ack_delay = 1;
    run_pulse();
    begin
      int n;
      n = 0;
      while (!bus.oMemReq && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("mid_mem_reached", int'(bus.oMemReq), 1);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_pc", int'(bus.oPC), 0);
    chk("mid_rst_mem_addr", int'(bus.oMemAddr), 0);
    chk("mid_rst_mem_req", int'(bus.oMemReq), 0);
    chk("mid_rst_halt", int'(bus.oHalt), 0);
    chk("mid_rst_acc_we", int'(bus.oAccWe), 0);
    repeat (3) @(negedge clk);
    chk("mid_rst_idle_pc", int'(bus.oPC), 0);

    // PC wrap: 16 CLA from PC 0.
    do_reset();
    prog = '{};
    load_prog(8'h00);
    ack_en = 0;
    run_pulse();
    for (int k = 0; k < 16; k++) push(3'b000, 4'(k), run_cyc + 3 + 3 * k);
    while (cyc < run_cyc + 46) @(negedge clk);
    chk("wrap_pc15", int'(bus.oPC), 15);
    while (cyc < run_cyc + 49) @(negedge clk);
    chk("wrap_pc0", int'(bus.oPC), 0);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
